// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, STAGES segments of WIDTH/STAGES bits,
// valid/ready on both sides. Define CLA_SATURATE_EN to clamp signed overflow at the output.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  // Index j holds register Rj: operands, partial sum and carry into segment j.
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic [STAGES-1:0] c_r;
  logic [STAGES-1:0] v_r;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             vout_r;

  logic [WIDTH-1:0] sn [STAGES];
  logic [STAGES-1:0] cn;
  logic [STAGES:0]   ld;
  logic [WIDTH-1:0]  fin_s;
  logic              fin_ov;

  // Flattened lookahead: every carry is an OR of generate/propagate product terms.
  function automatic logic [SEG:0] lookahead(input logic [SEG-1:0] p,
                                             input logic [SEG-1:0] g,
                                             input logic           c0);
    logic [SEG:0] c;
    logic         term;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < SEG; i++) begin
      term = c0;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Segment resolution for every stage.
  always_comb begin : seg_logic
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   cc;
    p  = '0;
    g  = '0;
    cc = '0;
    cn = '0;
    for (int j = 0; j < STAGES; j++) begin
      p     = a_r[j][j*SEG +: SEG] ^ b_r[j][j*SEG +: SEG];
      g     = a_r[j][j*SEG +: SEG] & b_r[j][j*SEG +: SEG];
      cc    = lookahead(p, g, c_r[j]);
      sn[j] = s_r[j];
      sn[j][j*SEG +: SEG] = p ^ cc[SEG-1:0];
      cn[j] = cc[SEG];
    end
  end

  // A register may load unless it and everything downstream is full and the sink stalls.
  always_comb begin : load_logic
    logic full_tail;
    ld         = '0;
    full_tail  = vout_r;
    ld[STAGES] = ~vout_r | out_ready;
    for (int j = STAGES - 1; j >= 0; j--) begin
      full_tail = full_tail & v_r[j];
      ld[j]     = ~full_tail | out_ready;
    end
  end

  // Overflow uses the captured b_eff sign; clamping happens before the output register.
  always_comb begin
    fin_ov = (a_r[STAGES-1][WIDTH-1] == b_r[STAGES-1][WIDTH-1]) &
             (sn[STAGES-1][WIDTH-1] != a_r[STAGES-1][WIDTH-1]);
`ifdef CLA_SATURATE_EN
    if (fin_ov) begin
      fin_s = a_r[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      fin_s = sn[STAGES-1];
    end
`else
    fin_s = sn[STAGES-1];
`endif
  end

  // Pipeline registers; data only moves with a valid token to limit toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < STAGES; j++) begin
        a_r[j] <= '0;
        b_r[j] <= '0;
        s_r[j] <= '0;
      end
      c_r    <= '0;
      v_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      vout_r <= 1'b0;
    end else begin
      if (ld[0]) begin
        v_r[0] <= in_valid;
        if (in_valid) begin
          a_r[0] <= a;
          b_r[0] <= sub ? ~b : b;
          s_r[0] <= '0;
          c_r[0] <= sub | cin;
        end
      end
      for (int j = 1; j < STAGES; j++) begin
        if (ld[j]) begin
          v_r[j] <= v_r[j-1];
          if (v_r[j-1]) begin
            a_r[j] <= a_r[j-1];
            b_r[j] <= b_r[j-1];
            s_r[j] <= sn[j-1];
            c_r[j] <= cn[j-1];
          end
        end
      end
      if (ld[STAGES]) begin
        vout_r <= v_r[STAGES-1];
        if (v_r[STAGES-1]) begin
          sum_r  <= fin_s;
          cout_r <= cn[STAGES-1];
          ovf_r  <= fin_ov;
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vout_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: vector table, scoreboard queue,
// latency, backpressure, mid-flight reset and random handshake traffic.
module tb_pipelined_cla_adder;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef CLA_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [31:0] SMAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SMIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow;
  logic [WIDTH-1:0] a, b, sum;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  res_t exp_q[$];
  res_t cur;
  vec_t tbl [12];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   last_ov;
  bit   saw_full;
  bit   rand_rdy;
  int   stall_cyc;
  bit   acc;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, expv);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic sb);
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   t;
    res_t r;
    be   = sb ? ~y : y;
    t    = {1'b0, x} + {1'b0, be} + {{WIDTH{1'b0}}, (sb ? 1'b1 : ci)};
    r.s  = t[WIDTH-1:0];
    r.co = t[WIDTH];
    r.ov = (x[WIDTH-1] == be[WIDTH-1]) && (r.s[WIDTH-1] != x[WIDTH-1]);
    if (SAT && r.ov) r.s = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return r;
  endfunction

  // One clock: sample mid-cycle, score handshakes, then advance past the edge.
  task automatic step(output bit accepted);
    res_t e;
    @(negedge clk);
    last_ov = out_valid;
    chk1("in_ready", in_ready, ((exp_q.size() < STAGES + 1) || out_ready) ? 1'b1 : 1'b0);
    if (in_valid && !in_ready) saw_full = 1'b1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got sum %h expected none", sum);
      end else begin
        e = exp_q.pop_front();
        chk("sum", sum, e.s);
        chk1("cout", cout, e.co);
        chk1("overflow", overflow, e.ov);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(cur);
    @(posedge clk);
    #1;
    if (stall_cyc > 0) begin
      stall_cyc--;
      out_ready = (stall_cyc == 0);
    end else if (rand_rdy) begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                      input logic ci, input logic sb, input res_t e);
    bit got;
    got      = 1'b0;
    a        = x;
    b        = y;
    cin      = ci;
    sub      = sb;
    cur      = e;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) step(got);
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got in_ready stuck low expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step(acc);
    chk1("drain_empty", exp_q.size() == 0, 1'b1);
    for (int i = 0; i < 6; i++) step(acc);
  endtask

  task automatic lat(input vec_t v);
    res_t e;
    e.s = v.s; e.co = v.co; e.ov = v.ov;
    send(v.a, v.b, v.cin, v.sub, e);
    for (int i = 1; i <= STAGES; i++) begin
      step(acc);
      chk1("latency_early", last_ov, 1'b0);
    end
    step(acc);
    chk1("latency_due", last_ov, 1'b1);
    chk1("latency_popped", exp_q.size() == 0, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, SAT ? SMIN : 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[4]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, SAT ? SMAX : 32'h8000_0000, 1'b0, 1'b1};
    tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, SAT ? SMIN : 32'h0000_0000, 1'b1, 1'b1};
    tbl[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
    tbl[7]  = '{32'h0000_0007, 32'h0000_0007, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[9]  = '{32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, SAT ? SMAX : 32'h8000_0000, 1'b0, 1'b1};
    tbl[10] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    saw_full = 1'b0; rand_rdy = 1'b0; stall_cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_sum", sum, '0);
    chk1("reset_cout", cout, 1'b0);
    chk1("reset_overflow", overflow, 1'b0);
    rst = 1'b0;
    #1;
    chk1("reset_in_ready", in_ready, 1'b1);

    lat(tbl[0]);

    // Back-to-back table vectors with expectations taken from the table itself.
    for (int i = 0; i < 12; i++) begin
      res_t e;
      e.s = tbl[i].s; e.co = tbl[i].co; e.ov = tbl[i].ov;
      send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
    end
    drain();

    // Backpressure: hold out_ready low for 6 cycles after the second operation.
    saw_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [WIDTH-1:0] x, y;
      logic sb, ci;
      x = $urandom; y = $urandom; sb = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      if (i == 2) begin
        stall_cyc = 6;
        out_ready = 1'b0;
      end
      send(x, y, ci, sb, model(x, y, ci, sb));
    end
    drain();
    chk1("bp_stall_seen", saw_full, 1'b1);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] x, y;
      x = $urandom; y = $urandom;
      send(x, y, 1'b0, 1'b0, model(x, y, 1'b0, 1'b0));
    end
    rst = 1'b1;
    #1;
    chk1("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_sum", sum, '0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(acc);
    lat(tbl[2]);

    // Random traffic with random gaps and random downstream stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] x, y;
      logic sb, ci;
      if ($urandom_range(0, 3) == 0) step(acc);
      x = $urandom; y = $urandom; sb = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
      if (i % 37 == 0) y = sb ? x : ~x;
      send(x, y, ci, sb, model(x, y, ci, sb));
    end
    rand_rdy = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
